// File: rtl/piece_lock.sv
// Locks a four-cell piece into the board: capture, range check, one cell write per
// cycle, then wait for the board's line-clear validation and accumulate cleared lines.
module piece_lock #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lock_req,
    input  logic [15:0] cells_x,
    input  logic [19:0] cells_y,
    input  logic [23:0] piece_colour,
    input  logic        validate_done_flag,
    input  logic [1:0]  lines_cleared,
    output logic [3:0]  board_x,
    output logic [4:0]  board_y,
    output logic [23:0] write_colour,
    output logic        validate_start,
    output logic        write_done,
    output logic        busy,
    output logic        lock_done,
    output logic        lock_err,
    output logic [1:0]  last_lines,
    output logic [15:0] total_lines
);
    // state    | meaning
    // IDLE     | waiting for lock_req, piece inputs captured on request
    // CHECK    | range check of the captured cells
    // WRITE    | one cell per cycle to the board, idx 0..3
    // DONE     | write_done pulse
    // WAIT_VAL | waiting for validation, bounded by TIMEOUT
    // REPORT   | lock_done pulse, total updated on exit
    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_WRITE, S_DONE, S_WAIT_VAL, S_REPORT
    } state_t;

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t         state_q, state_d;
    logic [1:0]     idx_q, idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [15:0]    cx_q, cx_d;
    logic [19:0]    cy_q, cy_d;
    logic [23:0]    col_q, col_d;
    logic [1:0]     last_q, last_d;
    logic [15:0]    total_q, total_d;

    logic           range_err;
    logic [3:0]     cell_x;
    logic [4:0]     cell_y;
    logic [16:0]    sum;

    always_comb begin
        range_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (int'(cx_q[4*i +: 4]) >= BOARD_W || int'(cy_q[5*i +: 5]) >= BOARD_H)
                range_err = 1'b1;
        end
    end

    always_comb begin
        cell_x = cx_q[3:0];
        cell_y = cy_q[4:0];
        case (idx_q)
            2'd1: begin cell_x = cx_q[7:4];   cell_y = cy_q[9:5];   end
            2'd2: begin cell_x = cx_q[11:8];  cell_y = cy_q[14:10]; end
            2'd3: begin cell_x = cx_q[15:12]; cell_y = cy_q[19:15]; end
            default: ;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        cx_d           = cx_q;
        cy_d           = cy_q;
        col_d          = col_q;
        last_d         = last_q;
        total_d        = total_q;
        board_x        = '0;
        board_y        = '0;
        write_colour   = '0;
        validate_start = 1'b0;
        write_done     = 1'b0;
        lock_done      = 1'b0;
        lock_err       = 1'b0;
        busy           = (state_q != S_IDLE);
        sum            = {1'b0, total_q} + {15'd0, last_q};

        case (state_q)
            S_IDLE: begin
                if (lock_req) begin
                    cx_d    = cells_x;
                    cy_d    = cells_y;
                    col_d   = piece_colour;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (range_err) begin
                    lock_err = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    idx_d   = '0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                validate_start = 1'b1;
                board_x        = cell_x;
                board_y        = cell_y;
                write_colour   = col_q;
                idx_d          = idx_q + 2'd1;
                if (idx_q == 2'd3)
                    state_d = S_DONE;
            end
            S_DONE: begin
                write_done = 1'b1;
                cnt_d      = '0;
                state_d    = S_WAIT_VAL;
            end
            S_WAIT_VAL: begin
                // the flag takes priority over a timeout landing in the same cycle
                if (validate_done_flag) begin
                    last_d  = lines_cleared;
                    state_d = S_REPORT;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    lock_err = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_REPORT: begin
                lock_done = 1'b1;
                total_d   = sum[16] ? 16'hFFFF : sum[15:0];
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            col_q   <= '0;
            last_q  <= '0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            col_q   <= col_d;
            last_q  <= last_d;
            total_q <= total_d;
        end
    end

    assign last_lines  = last_q;
    assign total_lines = total_q;
endmodule

// File: tb/tb_piece_lock.sv
// Self-checking bench for piece_lock: a per-cycle expectation trace is planned from the
// lock rules for each directed lock and compared every cycle, plus literal latency checks.
module tb_piece_lock;
    localparam int BW = 10;
    localparam int BH = 20;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lock_req = 1'b0;
    logic [15:0] cells_x = '0;
    logic [19:0] cells_y = '0;
    logic [23:0] piece_colour = '0;
    logic        validate_done_flag = 1'b0;
    logic [1:0]  lines_cleared = '0;
    logic [3:0]  board_x;
    logic [4:0]  board_y;
    logic [23:0] write_colour;
    logic        validate_start;
    logic        write_done;
    logic        busy;
    logic        lock_done;
    logic        lock_err;
    logic [1:0]  last_lines;
    logic [15:0] total_lines;

    always #5 clk = ~clk;

    piece_lock #(.BOARD_W(BW), .BOARD_H(BH), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .lock_req(lock_req), .cells_x(cells_x), .cells_y(cells_y),
        .piece_colour(piece_colour), .validate_done_flag(validate_done_flag),
        .lines_cleared(lines_cleared), .board_x(board_x), .board_y(board_y),
        .write_colour(write_colour), .validate_start(validate_start), .write_done(write_done),
        .busy(busy), .lock_done(lock_done), .lock_err(lock_err), .last_lines(last_lines),
        .total_lines(total_lines)
    );

    typedef struct packed {
        logic [3:0]  bx;
        logic [4:0]  by;
        logic [23:0] wc;
        logic        vs;
        logic        wd;
        logic        busy;
        logic        done;
        logic        err;
        logic [1:0]  last;
        logic [15:0] total;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_total = '0;
    logic [1:0]  m_last = '0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vs_cnt = 0, n_wd = 0, n_done = 0, n_err = 0;
    int t_wd = 0, t_done = 0, t_err = 0, t_req = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t idle_e();
        exp_t e;
        e = '0;
        e.last  = m_last;
        e.total = m_total;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (validate_start) vs_cnt++;
        if (write_done) begin n_wd++; t_wd = cyc; end
        if (lock_done) begin n_done++; t_done = cyc; end
        if (lock_err) begin n_err++; t_err = cyc; end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("board_x", 32'(board_x), 32'(e.bx));
            chk("board_y", 32'(board_y), 32'(e.by));
            chk("write_colour", 32'(write_colour), 32'(e.wc));
            chk("validate_start", 32'(validate_start), 32'(e.vs));
            chk("write_done", 32'(write_done), 32'(e.wd));
            chk("busy", 32'(busy), 32'(e.busy));
            chk("lock_done", 32'(lock_done), 32'(e.done));
            chk("lock_err", 32'(lock_err), 32'(e.err));
            chk("last_lines", 32'(last_lines), 32'(e.last));
            chk("total_lines", 32'(total_lines), 32'(e.total));
        end
    end

    // d = flag delay in cycles after write_done (0 = never), hold_req keeps lock_req high
    task automatic run_lock(input logic [15:0] px, input logic [19:0] py, input logic [23:0] col,
                            input int d, input logic [1:0] lines, input bit hold_req);
        exp_t e;
        int   n;
        int   t;
        bit   bad;
        bad = 1'b0;
        for (int i = 0; i < 4; i++)
            if (int'(px[4*i +: 4]) >= BW || int'(py[5*i +: 5]) >= BH) bad = 1'b1;
        e = idle_e(); exp_q.push_back(e);
        e = idle_e(); e.busy = 1'b1; e.err = bad; exp_q.push_back(e);
        if (!bad) begin
            for (int i = 0; i < 4; i++) begin
                e = idle_e(); e.busy = 1'b1; e.vs = 1'b1;
                e.bx = px[4*i +: 4]; e.by = py[5*i +: 5]; e.wc = col;
                exp_q.push_back(e);
            end
            e = idle_e(); e.busy = 1'b1; e.wd = 1'b1; exp_q.push_back(e);
            if (d >= 1 && d <= TO) begin
                for (int k = 0; k < d; k++) begin
                    e = idle_e(); e.busy = 1'b1; exp_q.push_back(e);
                end
                m_last = lines;
                e = idle_e(); e.busy = 1'b1; e.done = 1'b1; exp_q.push_back(e);
                t = int'(m_total) + int'(m_last);
                if (t > 65535) t = 65535;
                m_total = 16'(t);
            end else begin
                for (int k = 0; k < TO - 1; k++) begin
                    e = idle_e(); e.busy = 1'b1; exp_q.push_back(e);
                end
                e = idle_e(); e.busy = 1'b1; e.err = 1'b1; exp_q.push_back(e);
            end
        end
        e = idle_e(); exp_q.push_back(e);
        n = exp_q.size();
        t_req = cyc;
        for (int c = 0; c < n; c++) begin
            lock_req = (c == 0) || (hold_req && c < n - 1);
            if (c == 0) begin
                cells_x = px; cells_y = py; piece_colour = col;
            end else begin
                cells_x = 16'($urandom); cells_y = 20'($urandom); piece_colour = 24'($urandom);
            end
            if (d >= 1 && c == 6 + d) begin
                validate_done_flag = 1'b1; lines_cleared = lines;
            end else begin
                validate_done_flag = (c >= 2 && c <= 6);
                lines_cleared = 2'($urandom);
            end
            @(posedge clk); #1;
        end
        lock_req = 1'b0;
        validate_done_flag = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   vs0, wd0, dn0, er0;

        #1 rst = 1'b1;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_total", 32'(total_lines), 32'd0);
        chk("rst_last", 32'(last_lines), 32'd0);
        chk("rst_vs", 32'(validate_start), 32'd0);
        chk("rst_pulses", 32'({lock_done, lock_err, write_done}), 32'd0);
        chk("rst_board", 32'({board_x, board_y, write_colour}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // normal lock, flag three cycles after write_done
        vs0 = vs_cnt; wd0 = n_wd; dn0 = n_done;
        run_lock({4'd1, 4'd2, 4'd1, 4'd0}, {5'd18, 5'd19, 5'd19, 5'd19}, 24'd1, 3, 2'd0, 1'b0);
        chk("normal_latency", 32'(t_done - t_req), 32'd10);
        chk("normal_vs_count", 32'(vs_cnt - vs0), 32'd4);
        chk("normal_wd_count", 32'(n_wd - wd0), 32'd1);
        chk("normal_done_count", 32'(n_done - dn0), 32'd1);
        chk("normal_last", 32'(last_lines), 32'd0);

        // minimum latency with lock_req held throughout
        wd0 = n_wd;
        run_lock({4'd5, 4'd4, 4'd5, 4'd4}, {5'd1, 5'd1, 5'd0, 5'd0}, 24'h00FF00, 1, 2'd3, 1'b1);
        chk("min_latency", 32'(t_done - t_req), 32'd8);
        chk("held_req_wd_count", 32'(n_wd - wd0), 32'd1);
        chk("after3_total", 32'(total_lines), 32'd3);

        // range errors
        vs0 = vs_cnt;
        run_lock({4'd2, 4'd1, 4'd0, 4'd10}, 20'd0, 24'h123456, 3, 2'd1, 1'b0);
        chk("xerr_latency", 32'(t_err - t_req), 32'd1);
        chk("xerr_vs_count", 32'(vs_cnt - vs0), 32'd0);
        chk("xerr_busy", 32'(busy), 32'd0);
        run_lock({4'd3, 4'd3, 4'd3, 4'd3}, {5'd20, 5'd0, 5'd0, 5'd0}, 24'h654321, 3, 2'd1, 1'b0);
        chk("yerr_latency", 32'(t_err - t_req), 32'd1);
        chk("yerr_vs_count", 32'(vs_cnt - vs0), 32'd0);

        // timeout: no flag
        dn0 = n_done;
        run_lock({4'd0, 4'd1, 4'd2, 4'd3}, {5'd5, 5'd5, 5'd5, 5'd5}, 24'hFFFFFF, 0, 2'd3, 1'b0);
        chk("timeout_latency", 32'(t_err - t_wd), 32'd16);
        chk("timeout_done_count", 32'(n_done - dn0), 32'd0);
        chk("timeout_total", 32'(total_lines), 32'd3);

        // flag coinciding with the timeout cycle wins
        dn0 = n_done; er0 = n_err;
        run_lock({4'd6, 4'd7, 4'd8, 4'd9}, {5'd10, 5'd11, 5'd12, 5'd13}, 24'hA5A5A5, TO, 2'd2, 1'b0);
        chk("tie_done_count", 32'(n_done - dn0), 32'd1);
        chk("tie_err_count", 32'(n_err - er0), 32'd0);
        chk("tie_total", 32'(total_lines), 32'd5);

        // duplicate cells at the board corner
        vs0 = vs_cnt;
        run_lock({4{4'd9}}, {4{5'd19}}, 24'h0F0F0F, 2, 2'd1, 1'b0);
        chk("dup_vs_count", 32'(vs_cnt - vs0), 32'd4);
        chk("dup_total", 32'(total_lines), 32'd6);

        // reset while writing idx 2, with lock_req held through the reset
        e = idle_e(); exp_q.push_back(e);
        e = idle_e(); e.busy = 1'b1; exp_q.push_back(e);
        for (int i = 0; i < 2; i++) begin
            e = idle_e(); e.busy = 1'b1; e.vs = 1'b1;
            e.bx = 4'(3 + i); e.by = 5'(4 + i); e.wc = 24'hABCDEF;
            exp_q.push_back(e);
        end
        m_total = '0; m_last = '0;
        for (int k = 0; k < 4; k++) begin
            e = idle_e(); exp_q.push_back(e);
        end
        vs0 = vs_cnt; wd0 = n_wd; dn0 = n_done; er0 = n_err;
        for (int c = 0; c < 4; c++) begin
            lock_req = (c == 0);
            cells_x = {4'd6, 4'd5, 4'd4, 4'd3};
            cells_y = {5'd7, 5'd6, 5'd5, 5'd4};
            piece_colour = 24'hABCDEF;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("midrst_vs", 32'(validate_start), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_total", 32'(total_lines), 32'd0);
        lock_req = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        lock_req = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("midrst_vs_count", 32'(vs_cnt - vs0), 32'd2);
        chk("midrst_pulses", 32'((n_wd - wd0) + (n_done - dn0) + (n_err - er0)), 32'd0);

        // fresh lock after reset
        run_lock({4'd0, 4'd0, 4'd1, 4'd1}, {5'd3, 5'd2, 5'd3, 5'd2}, 24'h000001, 5, 2'd2, 1'b0);
        chk("fresh_total", 32'(total_lines), 32'd2);
        chk("fresh_last", 32'(last_lines), 32'd2);

        // saturation from a preloaded total
        force dut.total_q = 16'hFFFE;
        @(posedge clk); #1;
        release dut.total_q;
        m_total = 16'hFFFE;
        chk("preload_total", 32'(total_lines), 32'h0000FFFE);
        run_lock({4'd2, 4'd3, 4'd4, 4'd5}, {5'd8, 5'd8, 5'd8, 5'd8}, 24'h777777, 1, 2'd3, 1'b0);
        chk("sat_total", 32'(total_lines), 32'h0000FFFF);
        run_lock({4'd2, 4'd3, 4'd4, 4'd5}, {5'd9, 5'd9, 5'd9, 5'd9}, 24'h888888, 4, 2'd1, 1'b0);
        chk("sat_hold_total", 32'(total_lines), 32'h0000FFFF);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/piece_lock.md
PIECE_LOCK -- requirements
Module: piece_lock

Interface
REQ-001 Parameter BOARD_W, default 10, meaning board width in cells; legal x is 0..BOARD_W-1.
REQ-002 Parameter BOARD_H, default 20, meaning board height in cells; legal y is 0..BOARD_H-1.
REQ-003 Parameter TIMEOUT, default 4096, meaning maximum cycles spent in WAIT_VAL before abort.
REQ-004 The block SHALL have one clock, clk; reset, rst, is asynchronous and active-high.
REQ-005 Ports SHALL be exactly as follows:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- lock_req  in  1  request to lock the presented piece.
- cells_x  in  16  four 4-bit x coordinates; cell i at bits [4i+3:4i].
- cells_y  in  20  four 5-bit y coordinates; cell i at bits [5i+4:5i].
- piece_colour  in  24  colour written for all four cells.
- validate_done_flag  in  1  board finished line-clear validation.
- lines_cleared  in  2  lines cleared by the board, valid with validate_done_flag.
- board_x  out  4  cell column driven to the board.
- board_y  out  5  cell row driven to the board.
- write_colour  out  24  colour driven to the board.
- validate_start  out  1  board write enable for the current board_x/board_y.
- write_done  out  1  one-cycle pulse that starts board validation.
- busy  out  1  high in every state except IDLE.
- lock_done  out  1  one-cycle pulse on successful completion.
- lock_err  out  1  one-cycle pulse on a range error or timeout.
- last_lines  out  2  lines_cleared captured on the last success.
- total_lines  out  16  saturating running total of cleared lines.

Function
REQ-006 The block SHALL implement the states IDLE, CHECK, WRITE, DONE, WAIT_VAL and REPORT.
REQ-007 In IDLE, when lock_req=1, the block SHALL register cells_x, cells_y and piece_colour and enter CHECK on the next cycle.
REQ-008 lock_req SHALL be ignored in every state other than IDLE; later changes to the piece inputs SHALL NOT affect an in-progress lock.
REQ-009 CHECK SHALL last one cycle: if any captured x ≥ BOARD_W or y ≥ BOARD_H, the block SHALL pulse lock_err, perform no board write and return to IDLE; otherwise it SHALL enter WRITE with idx=0.
REQ-010 WRITE SHALL last exactly 4 cycles with validate_start=1, presenting cell idx on board_x/board_y and the captured colour on write_colour, idx 0,1,2,3 in order.
REQ-011 Duplicate coordinates SHALL be written as presented, without merging or error.
REQ-012 DONE SHALL last one cycle with validate_start=0 and write_done=1, then enter WAIT_VAL.
REQ-013 WAIT_VAL SHALL keep write_done=0, increment a wait counter each cycle, and leave on validate_done_flag=1 by capturing lines_cleared into last_lines and entering REPORT.
REQ-014 If the wait counter reaches TIMEOUT-1 without validate_done_flag, the block SHALL pulse lock_err, leave last_lines and total_lines unchanged, and return to IDLE.
REQ-015 If validate_done_flag and the timeout occur in the same cycle, validate_done_flag SHALL win.
REQ-016 REPORT SHALL last one cycle: lock_done=1, total_lines += last_lines saturating at 16'hFFFF, then return to IDLE.
REQ-017 Outside WRITE, board_x, board_y and write_colour SHALL be 0 and validate_start SHALL be 0.
REQ-018 validate_done_flag outside WAIT_VAL SHALL be ignored.
REQ-019 Minimum lock latency from lock_req to lock_done SHALL be 8 cycles (1 capture, 1 CHECK, 4 WRITE, 1 DONE, at least 1 WAIT_VAL) plus the REPORT cycle.

Reset
REQ-020 rst=1 SHALL immediately force IDLE and drive all outputs to 0, including total_lines, last_lines, busy, lock_done and lock_err.
REQ-021 rst asserted mid-lock SHALL abandon the lock with no further board writes and no lock_done or lock_err pulse; the first lock_req after release SHALL start a fresh lock.

Verification
REQ-022 Reset: rst pulse -> all outputs 0, busy=0, total_lines=0.
REQ-023 Normal lock: cells (0,19),(1,19),(2,19),(1,18), colour 24'd1, flag with lines_cleared=0 three cycles after write_done -> four consecutive validate_start cycles in that order, one write_done pulse, lock_done pulse, last_lines=0.
REQ-024 Range error: one cell x=10 -> lock_err pulse in the CHECK cycle, validate_start never asserted, busy low 2 cycles after lock_req.
REQ-025 Timeout: TIMEOUT=16, no flag -> lock_err 16 cycles after write_done, total_lines unchanged.
REQ-026 Accumulation and saturation: preload with 21845 locks of lines_cleared=3 (or force total_lines=16'hFFFE) then one lock with lines_cleared=3 -> total_lines=16'hFFFF.
REQ-027 Reset mid-WRITE and ignored lock_req: rst at idx=2 -> validate_start low immediately, no pulses; lock_req held during WAIT_VAL -> no second capture.
